period_to_freq: RTL and testbench
=================================

# period_to_freq

Sequential restoring divider that turns a measured signal period (in µs) into a frequency: quo = floor(NUM / prd), rmd = NUM mod prd. It sits directly downstream of the period counter in the auto low-frequency counter datapath. It latches the period word when told to start, iterates one quotient bit per clock, and hands the result on with a one-cycle done tick to the binary-to-BCD / display stage.

## Interface
- W, 20, operand width: period in, quotient out, remainder out.
- NUM, 1_000_000, constant numerator (1 s in µs). Must satisfy 0 < NUM < 2^W.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  request a division; sampled only while ready=1.
- prd  in  W  period from the period counter, in µs; sampled in the start cycle only.
- ready  out  1  high while idle; able to accept start.
- done_tick  out  1  one-cycle pulse when quo/rmd/div_zero are final.
- quo  out  W  quotient, i.e. frequency in Hz (integer part).
- rmd  out  W  remainder.
- div_zero  out  1  high if the last accepted prd was 0.

## Operation
- Registers:
  - state (idle, op, done);
  - dvsr (W bits);
  - rh (W bits, partial remainder);
  - rl (W bits, dividend shifting out / quotient shifting in);
  - n (iteration counter, ceil(log2(W+1)) bits);
  - dz flag.
- Outputs: quo = rl; rmd = rh; div_zero = dz. All are registered, with no combinational path from inputs.
- ready = (state==idle). done_tick = (state==done). Both are decoded from state only.
- idle, on start with prd≠0:
  - dvsr←prd, rh←0, rl←NUM, n←W, dz←0;
  - go to op.
- idle, on start with prd==0:
  - rl←all ones, rh←NUM[W-1:0], dz←1;
  - go to done with no iterations.
- op, each cycle:
  - tmp = {rh, rl[W-1]} (W+1 bits, unsigned compare);
  - if tmp ≥ dvsr: rh←tmp−dvsr and the quotient bit is 1;
  - otherwise rh←tmp[W-1:0] and the quotient bit is 0;
  - rl←{rl[W-2:0], quotient bit}; n←n−1;
  - when n==1, go to done.
- done: one cycle, then unconditionally idle.
- start outside idle is ignored. It is neither queued nor restarting.
- prd changes after the start cycle have no effect.
- quo/rmd/div_zero change only during op or in the start cycle. They hold their values from done through idle until the next accepted start.
- Remainder always < dvsr ≤ 2^W−1, so rh never overflows W bits.

## Timing
- Reset values: state=idle, ready=1, done_tick=0, quo=0, rmd=0, div_zero=0, n=0, dvsr=0.
- Cycle numbering: cycle 0 = the clock edge on which start is sampled with ready=1.
- prd≠0:
  - ready falls after edge 0;
  - op occupies edges 1..W;
  - done_tick is high for the single cycle after edge W;
  - ready returns after edge W+1.
  - Start-to-done_tick latency is W+1 cycles (21 with W=20).
- prd==0: done_tick is high for the single cycle after edge 0 (latency 1); ready returns after edge 1.
- Back-to-back: start held high continuously launches a new division on the first idle cycle. Throughput is one result per W+2 cycles.
- Reset asserted mid-operation: all registers go to reset values immediately (asynchronous). No done_tick is produced for the aborted division. ready=1 in the first cycle after release.
- Upstream pairing: period counter done_tick may drive start directly. prd is stable at that point and stays stable while the counter is idle.

## Test plan
- Reset, then idle: ready=1, done_tick=0, quo=0, rmd=0, div_zero=0. start=0 for 50 cycles causes no state change.
- prd=1000, start pulse → done_tick exactly 21 cycles later, for 1 cycle; quo=1000, rmd=0, div_zero=0. Values are held until the next start.
- prd=3 → quo=333333, rmd=1. prd=999999 → quo=1, rmd=1. prd=0xFFFFF → quo=0, rmd=1000000. prd=1 → quo=1000000, rmd=0.
- prd=0 → done_tick 1 cycle after start; quo=0xFFFFF, rmd=1000000 (0xF4240), div_zero=1. A following prd=7 run gives div_zero=0, quo=142857, rmd=1.
- start pulses at cycles 5 and 12 of a prd=250 run, with prd changed to 9 at cycle 3:
  - both pulses ignored;
  - result quo=4000, rmd=0;
  - exactly one done_tick.
- Reset asserted at cycle 10 of a prd=123 run:
  - outputs return to 0 asynchronously and no done_tick occurs;
  - after release, a prd=123 run gives quo=8130, rmd=10.
- Random prd in 1..2^20−1 (≥1000 vectors) checked against a reference model, including back-to-back starts with start held high.

Source files
------------

// File: rtl/period_to_freq.sv
// period_to_freq: sequential restoring divider, quo = NUM / prd, rmd = NUM % prd.
// Converts a measured period in microseconds into a frequency in Hz.
// One quotient bit is produced per clock. A division takes W+2 cycles from
// start to the next ready, and a one-cycle done_tick marks the final result.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the previous result
//   OP    | shifting/subtracting, one quotient bit per cycle, n counts down
//   DONE  | result final for one cycle (done_tick), then back to IDLE
module period_to_freq #(
  parameter int unsigned W   = 20,
  parameter int unsigned NUM = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] prd,
  output logic         ready,
  output logic         done_tick,
  output logic [W-1:0] quo,
  output logic [W-1:0] rmd,
  output logic         div_zero
);

  localparam int unsigned NW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [W-1:0] NUM_W = W'(NUM);

  logic [1:0]    state;
  logic [W-1:0]  dvsr;
  logic [W-1:0]  rh;
  logic [W-1:0]  rl;
  logic [NW-1:0] n;
  logic          dz;

  logic [W:0]    tmp;
  logic          q_bit;
  logic [W-1:0]  diff;

  // One restoring step: bring in the next dividend bit and trial-subtract.
  // When the subtraction succeeds the true result is below dvsr, so the low
  // W bits of the difference are exact and the carry out can be dropped.
  always_comb begin
    tmp   = {rh, rl[W-1]};
    q_bit = (tmp >= {1'b0, dvsr});
    diff  = tmp[W-1:0] - dvsr;
  end

  // Control state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dvsr  <= '0;
      rh    <= '0;
      rl    <= '0;
      n     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (prd == '0) begin
              // A zero period saturates the quotient and leaves the numerator
              // as remainder; no iterations are run.
              rl    <= '1;
              rh    <= NUM_W;
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              dvsr  <= prd;
              rh    <= '0;
              rl    <= NUM_W;
              n     <= NW'(W);
              dz    <= 1'b0;
              state <= OP;
            end
          end
        end
        OP: begin
          rh <= q_bit ? diff : tmp[W-1:0];
          rl <= {rl[W-2:0], q_bit};
          n  <= n - NW'(1);
          if (n == NW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign done_tick = (state == DONE);
  assign quo       = rl;
  assign rmd       = rh;
  assign div_zero  = dz;

endmodule

// File: tb/tb_period_to_freq.sv
// Directed and random checks for period_to_freq (W=20, NUM=1_000_000).
module tb_period_to_freq;

  localparam int unsigned W   = 20;
  localparam int unsigned NUM = 1_000_000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] prd;
  logic         ready;
  logic         done_tick;
  logic [W-1:0] quo;
  logic [W-1:0] rmd;
  logic         div_zero;

  int n_tests;
  int n_fail;

  period_to_freq #(.W(W), .NUM(NUM)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prd       (prd),
    .ready     (ready),
    .done_tick (done_tick),
    .quo       (quo),
    .rmd       (rmd),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one division from idle with a start pulse and check latency,
  // result, pulse width and return to ready.
  task automatic run_div(input logic [W-1:0] p, input string tag);
    int cnt;
    int unsigned eq;
    int unsigned er;
    if (p == 0) begin
      eq = 32'h000F_FFFF;
      er = NUM;
    end else begin
      eq = NUM / int'(p);
      er = NUM % int'(p);
    end
    @(negedge clk);
    prd   = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    check({tag, " ready_low"}, {31'd0, ready}, 32'd0);
    while (!done_tick && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, cnt, (p == 0) ? 32'd1 : 32'd21);
    check({tag, " quo"}, {12'd0, quo}, eq);
    check({tag, " rmd"}, {12'd0, rmd}, er);
    check({tag, " div_zero"}, {31'd0, div_zero}, (p == 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, " done_width"}, {31'd0, done_tick}, 32'd0);
    check({tag, " ready_back"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int dcount;
    int cnt;
    logic [W-1:0] q_cap;
    logic [W-1:0] r_cap;
    logic [W-1:0] vec [0:499];
    logic [W-1:0] cur;

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    prd     = '0;
    #23;
    reset = 1'b0;

    // Reset state and idle stability.
    @(negedge clk);
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst done", {31'd0, done_tick}, 32'd0);
    check("rst quo", {12'd0, quo}, 32'd0);
    check("rst rmd", {12'd0, rmd}, 32'd0);
    check("rst dz", {31'd0, div_zero}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_tick || !ready) dcount++;
    end
    check("idle stable", dcount, 0);
    check("idle quo", {12'd0, quo}, 32'd0);

    // Directed vectors.
    run_div(20'd1000, "p1000");
    repeat (10) @(negedge clk);
    check("hold quo", {12'd0, quo}, 32'd1000);
    check("hold rmd", {12'd0, rmd}, 32'd0);
    run_div(20'd3, "p3");
    run_div(20'd999999, "p999999");
    run_div(20'hFFFFF, "pmax");
    run_div(20'd1, "p1");
    run_div(20'd0, "p0");
    run_div(20'd7, "p7");

    // Starts during op are ignored and prd changes after the start cycle are too.
    @(negedge clk);
    prd   = 20'd250;
    start = 1'b1;
    dcount = 0;
    q_cap  = '0;
    r_cap  = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_tick) begin
        dcount++;
        q_cap = quo;
        r_cap = rmd;
      end
      if (c == 3) prd = 20'd9;
      if (c == 4 || c == 11) start = 1'b1;
    end
    start = 1'b0;
    check("ign done_cnt", dcount, 1);
    check("ign quo", {12'd0, q_cap}, 32'd4000);
    check("ign rmd", {12'd0, r_cap}, 32'd0);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    prd   = 20'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst quo", {12'd0, quo}, 32'd0);
    check("arst rmd", {12'd0, rmd}, 32'd0);
    check("arst ready", {31'd0, ready}, 32'd1);
    check("arst done", {31'd0, done_tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_tick) dcount++;
    end
    check("arst no_done", dcount, 0);
    run_div(20'd123, "p123");

    // Random vectors, one start pulse each.
    for (int i = 0; i < 500; i++) begin
      run_div(20'($urandom_range(1, 32'h000F_FFFF)), "rnd");
    end

    // Random back-to-back vectors with start held high.
    for (int i = 0; i < 500; i++) vec[i] = 20'($urandom_range(1, 32'h000F_FFFF));
    @(negedge clk);
    prd   = vec[0];
    start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      cur = vec[i];
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!done_tick && cnt < 100);
      check("b2b interval", cnt, (i == 0) ? 32'd21 : 32'd22);
      check("b2b quo", {12'd0, quo}, NUM / int'(cur));
      check("b2b rmd", {12'd0, rmd}, NUM % int'(cur));
      if (i == 499) start = 1'b0;
      else prd = vec[i + 1];
    end
    repeat (3) @(negedge clk);
    check("b2b idle", {31'd0, ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
